apb_master: RTL and testbench



---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_slave_decode.sv | 26 ++
 rtl/apb_master.sv | 205 ++++++++++++++++++++
 tb/tb_apb_master.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared constants and types for the APB requester.
//   - Default widths for address and data buses.
//   - Address bit that selects between the two slaves.
//   - Default ACCESS timeout length (used only when APB_TIMEOUT_EN is defined).
//   - Transfer FSM state encoding.
package apb_pkg;

   localparam int unsigned ADDR_W_DEF         = 8;
   localparam int unsigned DATA_W_DEF         = 8;
   localparam int unsigned SEL_BIT_DEF        = 7;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StSetup  = 2'd1,
      StAccess = 2'd2
   } apb_state_e;

endpackage

// File: rtl/apb_slave_decode.sv
// apb_slave_decode: two-slave address decoder and read-data multiplexer.
// Ports:
//   sel_i       address select bit (0 -> slave 1, 1 -> slave 2)
//   prdata1_i   read data from slave 1
//   prdata2_i   read data from slave 2
//   psel1_o     one-hot select for slave 1
//   psel2_o     one-hot select for slave 2
//   prdata_o    read data of the selected slave
module apb_slave_decode #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              sel_i,
   input  logic [DATA_W-1:0] prdata1_i,
   input  logic [DATA_W-1:0] prdata2_i,
   output logic              psel1_o,
   output logic              psel2_o,
   output logic [DATA_W-1:0] prdata_o
);

   always_comb begin
      psel1_o  = ~sel_i;
      psel2_o  = sel_i;
      prdata_o = sel_i ? prdata2_i : prdata1_i;
   end

endmodule

// File: rtl/apb_master.sv
// apb_master: APB requester for a two-slave segment.
// Turns valid/ready commands into APB SETUP/ACCESS transfers and reports each completion on a
// one-cycle rsp_valid strobe. All outputs are registered.
// Optional macro APB_TIMEOUT_EN: abort an ACCESS phase that sees no PREADY within
// TIMEOUT_CYCLES cycles and report it with rsp_err=1. Without it ACCESS waits forever and
// rsp_err is tied low.
// Ports:
//   PCLK, PRESET          clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_write/addr/wdata  command payload
//   rsp_valid/rdata/err   completion strobe, read data (0 for writes), timeout flag
//   PSEL1/PSEL2/PENABLE   APB control
//   PWRITE/PADDR/PWDATA   APB request
//   PRDATA1/PRDATA2       slave read data
//   PREADY                ORed slave ready
module apb_master
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_W         = ADDR_W_DEF,
   parameter int unsigned DATA_W         = DATA_W_DEF,
   parameter int unsigned SEL_BIT        = SEL_BIT_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              PSEL1,
   output logic              PSEL2,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA1,
   input  logic [DATA_W-1:0] PRDATA2,
   input  logic              PREADY
);

   apb_state_e        state_q, state_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              psel1_q, psel1_d;
   logic              psel2_q, psel2_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;

`ifdef APB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
   logic            rsp_err_q, rsp_err_d;
   logic [CntW-1:0] cnt_q, cnt_d;
`else
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT_CYCLES;
`endif

   logic              dec_sel;
   logic              dec_psel1;
   logic              dec_psel2;
   logic [DATA_W-1:0] dec_rdata;

   // In IDLE the decoder looks at the incoming command so the select can be registered at
   // accept; afterwards it follows the latched PADDR to steer read data.
   assign dec_sel = (state_q == StIdle) ? cmd_addr[SEL_BIT] : paddr_q[SEL_BIT];

   apb_slave_decode #(
      .DATA_W (DATA_W)
   ) u_decode (
      .sel_i     (dec_sel),
      .prdata1_i (PRDATA1),
      .prdata2_i (PRDATA2),
      .psel1_o   (dec_psel1),
      .psel2_o   (dec_psel2),
      .prdata_o  (dec_rdata)
   );

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      psel1_d     = psel1_q;
      psel2_d     = psel2_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
`ifdef APB_TIMEOUT_EN
      rsp_err_d   = rsp_err_q;
      cnt_d       = cnt_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               pwrite_d    = cmd_write;
               paddr_d     = cmd_addr;
               pwdata_d    = cmd_wdata;
               psel1_d     = dec_psel1;
               psel2_d     = dec_psel2;
               penable_d   = 1'b0;
               cmd_ready_d = 1'b0;
               state_d     = StSetup;
            end
         end

         StSetup: begin
            penable_d = 1'b1;
            state_d   = StAccess;
`ifdef APB_TIMEOUT_EN
            cnt_d     = '0;
`endif
         end

         StAccess: begin
            if (PREADY) begin
               rsp_rdata_d = pwrite_q ? '0 : dec_rdata;
               rsp_valid_d = 1'b1;
               psel1_d     = 1'b0;
               psel2_d     = 1'b0;
               penable_d   = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = StIdle;
`ifdef APB_TIMEOUT_EN
               rsp_err_d   = 1'b0;
            end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
               // Last allowed ACCESS cycle ended without PREADY: abort the transfer.
               rsp_rdata_d = '0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               psel1_d     = 1'b0;
               psel2_d     = 1'b0;
               penable_d   = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= StIdle;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         psel1_q     <= 1'b0;
         psel2_q     <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
`ifdef APB_TIMEOUT_EN
         rsp_err_q   <= 1'b0;
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         psel1_q     <= psel1_d;
         psel2_q     <= psel2_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
`ifdef APB_TIMEOUT_EN
         rsp_err_q   <= rsp_err_d;
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign PSEL1     = psel1_q;
   assign PSEL2     = psel2_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
`ifdef APB_TIMEOUT_EN
   assign rsp_err   = rsp_err_q;
`else
   assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed, table-driven bench for apb_master with a two-slave memory model.
module tb_apb_master;

   logic       PCLK;
   logic       PRESET;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [7:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       PSEL1;
   logic       PSEL2;
   logic       PENABLE;
   logic       PWRITE;
   logic [7:0] PADDR;
   logic [7:0] PWDATA;
   logic [7:0] PRDATA1;
   logic [7:0] PRDATA2;
   logic       PREADY;

   int n_cmp;
   int n_err;

   apb_master u_dut (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .PSEL1     (PSEL1),
      .PSEL2     (PSEL2),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PRDATA1   (PRDATA1),
      .PRDATA2   (PRDATA2),
      .PREADY    (PREADY)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // Slave memories: write on a completing ACCESS cycle, read combinationally.
   logic [7:0] mem1 [128];
   logic [7:0] mem2 [128];
   always @(posedge PCLK) begin
      if (PSEL1 && PENABLE && PREADY && PWRITE) mem1[PADDR[6:0]] <= PWDATA;
      if (PSEL2 && PENABLE && PREADY && PWRITE) mem2[PADDR[6:0]] <= PWDATA;
   end
   assign PRDATA1 = mem1[PADDR[6:0]];
   assign PRDATA2 = mem2[PADDR[6:0]];

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      int         waits;
      logic [7:0] exp_rdata;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
      chk({tag, "_rsp_err"},   rsp_err,   0);
      chk({tag, "_psel1"},     PSEL1,     0);
      chk({tag, "_psel2"},     PSEL2,     0);
      chk({tag, "_penable"},   PENABLE,   0);
      chk({tag, "_pwrite"},    PWRITE,    0);
      chk({tag, "_paddr"},     PADDR,     0);
      chk({tag, "_pwdata"},    PWDATA,    0);
   endtask

   // Accept a command, step through SETUP, stall ACCESS for v.waits cycles, then check the
   // completion strobe and that it lasts one cycle.
   task automatic run_txn(input vec_t v);
      logic e1;
      logic e2;
      e1 = ~v.addr[7];
      e2 = v.addr[7];
      @(negedge PCLK);
      chk("idle_cmd_ready", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_write = v.wr;
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      // A zero-wait slave shows PREADY early; it must be ignored in IDLE and SETUP.
      PREADY    = (v.waits == 0);
      @(posedge PCLK); #1;
      cmd_valid = 1'b0;
      cmd_addr  = ~v.addr;
      cmd_wdata = 8'hFF;
      chk("setup_psel1",     PSEL1,     e1);
      chk("setup_psel2",     PSEL2,     e2);
      chk("setup_penable",   PENABLE,   0);
      chk("setup_pwrite",    PWRITE,    v.wr);
      chk("setup_paddr",     PADDR,     v.addr);
      chk("setup_pwdata",    PWDATA,    v.wdata);
      chk("setup_cmd_ready", cmd_ready, 0);
      chk("setup_rsp_valid", rsp_valid, 0);
      @(posedge PCLK); #1;
      chk("access_psel1",     PSEL1,     e1);
      chk("access_psel2",     PSEL2,     e2);
      chk("access_penable",   PENABLE,   1);
      chk("access_rsp_valid", rsp_valid, 0);
      for (int w = 0; w < v.waits; w++) begin
         @(posedge PCLK); #1;
         chk("stall_psel1",     PSEL1,     e1);
         chk("stall_psel2",     PSEL2,     e2);
         chk("stall_penable",   PENABLE,   1);
         chk("stall_paddr",     PADDR,     v.addr);
         chk("stall_pwdata",    PWDATA,    v.wdata);
         chk("stall_rsp_valid", rsp_valid, 0);
         if (w == v.waits - 1) PREADY = 1'b1;
      end
      @(posedge PCLK); #1;
      PREADY = 1'b0;
      chk("done_rsp_valid", rsp_valid, 1);
      chk("done_rsp_rdata", rsp_rdata, v.exp_rdata);
      chk("done_rsp_err",   rsp_err,   0);
      chk("done_psel1",     PSEL1,     0);
      chk("done_psel2",     PSEL2,     0);
      chk("done_penable",   PENABLE,   0);
      chk("done_cmd_ready", cmd_ready, 1);
      @(posedge PCLK); #1;
      chk("post_rsp_valid", rsp_valid, 0);
      chk("post_rsp_rdata", rsp_rdata, v.exp_rdata);
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      PRESET    = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = 8'h00;
      cmd_wdata = 8'h00;
      PREADY    = 1'b0;

      //          wr    addr   wdata  waits exp_rdata
      vecs[0] = '{1'b1, 8'h05, 8'hA5, 0,  8'h00};
      vecs[1] = '{1'b0, 8'h05, 8'h00, 0,  8'hA5};
      vecs[2] = '{1'b1, 8'h85, 8'h3C, 0,  8'h00};
      vecs[3] = '{1'b0, 8'h85, 8'h00, 0,  8'h3C};
      vecs[4] = '{1'b0, 8'h05, 8'h11, 4,  8'hA5};
      vecs[5] = '{1'b1, 8'h10, 8'h5A, 2,  8'h00};
      vecs[6] = '{1'b1, 8'h90, 8'hC3, 1,  8'h00};
      vecs[7] = '{1'b0, 8'h10, 8'h00, 1,  8'h5A};
      // PREADY arrives on the 16th ACCESS cycle: a normal completion even with the timeout.
      vecs[8] = '{1'b0, 8'h90, 8'h00, 15, 8'hC3};

      repeat (2) @(posedge PCLK);
      #1;
      chk_reset_vals("reset");
      @(negedge PCLK);
      PRESET = 1'b0;

      for (int i = 0; i < 9; i++) run_txn(vecs[i]);

      // Reset in the middle of a stalled ACCESS phase.
      @(negedge PCLK);
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 8'h20;
      cmd_wdata = 8'h77;
      PREADY    = 1'b0;
      @(posedge PCLK); #1;
      cmd_valid = 1'b0;
      repeat (3) @(posedge PCLK);
      #1;
      chk("midrst_in_access", PENABLE, 1);
      @(negedge PCLK);
      PRESET = 1'b1;
      @(posedge PCLK); #1;
      chk_reset_vals("midrst");
      @(negedge PCLK);
      PRESET = 1'b0;
      PREADY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge PCLK); #1;
         chk("midrst_no_rsp", rsp_valid, 0);
         chk("midrst_idle_psel", {PSEL1, PSEL2}, 0);
      end
      PREADY = 1'b0;
      run_txn(vecs[3]);

`ifdef APB_TIMEOUT_EN
      // Slave never answers: abort after 16 ACCESS cycles with rsp_err.
      @(negedge PCLK);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 8'h05;
      PREADY    = 1'b0;
      @(posedge PCLK); #1;
      cmd_valid = 1'b0;
      @(posedge PCLK); #1;
      chk("to_access_penable", PENABLE, 1);
      for (int i = 0; i < 15; i++) begin
         @(posedge PCLK); #1;
         chk("to_wait_psel1",     PSEL1,     1);
         chk("to_wait_rsp_valid", rsp_valid, 0);
      end
      @(posedge PCLK); #1;
      chk("to_rsp_valid", rsp_valid, 1);
      chk("to_rsp_err",   rsp_err,   1);
      chk("to_rsp_rdata", rsp_rdata, 0);
      chk("to_psel1",     PSEL1,     0);
      chk("to_penable",   PENABLE,   0);
      chk("to_cmd_ready", cmd_ready, 1);
      @(posedge PCLK); #1;
      chk("to_post_rsp_valid", rsp_valid, 0);
      run_txn(vecs[1]);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
